// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and defaults for the ID-stage sequencer.
//   id_seq_state_e      - sequencer FSM states
//   LSU_TIMEOUT_DEFAULT - default WAIT_LSU cycle budget
package ibex_pkg;

    typedef enum logic [2:0] {
        FIRST,
        MULTI_JUMP,
        MULTI_BRANCH,
        WAIT_LSU,
        WAIT_MD
    } id_seq_state_e;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ibex_sat_counter.sv
// ibex_sat_counter: counter that stops at all-ones.
//   clk   - clock
//   rst   - synchronous active-high clear
//   en    - count enable
//   count - current value, holds at all-ones
module ibex_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (en && count != '1) count <= count + 1'b1;
    end

endmodule

// File: rtl/ibex_id_seq.sv
// ibex_id_seq: ID-stage multi-cycle instruction sequencer.
//   CK, RST                          - clock, synchronous active-high reset
//   instr_valid_i, illegal_insn_i    - instruction present / illegal
//   jump/branch/data_req/mult/div    - decoder classification
//   branch_taken_i                   - branch comparison result (FIRST only)
//   lsu_resp_valid_i, lsu_err_i      - LSU response and error
//   multdiv_done_i                   - multiplier/divider finished
//   flush_i                          - abort current instruction
//   instr_new_o, instr_done_o        - first cycle / retire
//   pc_set_o, lsu_req_o, multdiv_en_o, exc_o, stall_o, stall_cnt_o
module ibex_id_seq
    import ibex_pkg::*;
#(
    parameter int unsigned LSU_TIMEOUT = LSU_TIMEOUT_DEFAULT,
    parameter bit          RV32M       = 1'b1
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        instr_valid_i,
    input  logic        illegal_insn_i,
    input  logic        jump_in_dec_i,
    input  logic        branch_in_dec_i,
    input  logic        data_req_dec_i,
    input  logic        mult_en_dec_i,
    input  logic        div_en_dec_i,
    input  logic        branch_taken_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_err_i,
    input  logic        multdiv_done_i,
    input  logic        flush_i,
    output logic        instr_new_o,
    output logic        instr_done_o,
    output logic        pc_set_o,
    output logic        lsu_req_o,
    output logic        multdiv_en_o,
    output logic        exc_o,
    output logic        stall_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(LSU_TIMEOUT - 1);

    id_seq_state_e state, next_state;
    logic [7:0]    wait_cnt;
    logic          md_req;
    logic          timeout;
    logic          abort;

    assign md_req  = RV32M & (mult_en_dec_i | div_en_dec_i);
    assign timeout = wait_cnt == TIMEOUT_LAST;
    // Reset also silences outputs so an abandoned instruction never retires.
    assign abort   = flush_i | RST;

    always_ff @(posedge CK) begin
        if (RST) begin
            state    <= FIRST;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == WAIT_LSU && !flush_i) ? wait_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FIRST: if (instr_valid_i && !illegal_insn_i) begin
                if (jump_in_dec_i) next_state = MULTI_JUMP;
                else if (branch_in_dec_i) next_state = branch_taken_i ? MULTI_BRANCH : FIRST;
                else if (data_req_dec_i) next_state = WAIT_LSU;
                else if (md_req) next_state = WAIT_MD;
            end
            MULTI_JUMP, MULTI_BRANCH: next_state = FIRST;
            WAIT_LSU: if (lsu_resp_valid_i || timeout) next_state = FIRST;
            WAIT_MD: if (multdiv_done_i) next_state = FIRST;
            default: next_state = FIRST;
        endcase
        if (flush_i) next_state = FIRST;
    end

    always_comb begin
        instr_new_o  = 1'b0;
        instr_done_o = 1'b0;
        pc_set_o     = 1'b0;
        lsu_req_o    = 1'b0;
        multdiv_en_o = 1'b0;
        exc_o        = 1'b0;
        case (state)
            FIRST: if (instr_valid_i) begin
                instr_new_o = 1'b1;
                if (illegal_insn_i) begin
                    exc_o        = 1'b1;
                    instr_done_o = 1'b1;
                end else if (jump_in_dec_i) pc_set_o = 1'b1;
                else if (branch_in_dec_i) instr_done_o = ~branch_taken_i;
                else if (data_req_dec_i) lsu_req_o = 1'b1;
                else if (md_req) multdiv_en_o = 1'b1;
                else instr_done_o = 1'b1;
            end
            MULTI_JUMP: instr_done_o = 1'b1;
            MULTI_BRANCH: begin
                pc_set_o     = 1'b1;
                instr_done_o = 1'b1;
            end
            // A response in the timeout cycle takes precedence.
            WAIT_LSU: if (lsu_resp_valid_i || timeout) begin
                instr_done_o = 1'b1;
                exc_o        = lsu_resp_valid_i ? lsu_err_i : 1'b1;
            end
            WAIT_MD: begin
                multdiv_en_o = 1'b1;
                instr_done_o = multdiv_done_i;
            end
            default: ;
        endcase
        if (abort) begin
            instr_new_o  = 1'b0;
            instr_done_o = 1'b0;
            pc_set_o     = 1'b0;
            lsu_req_o    = 1'b0;
            multdiv_en_o = 1'b0;
            exc_o        = 1'b0;
        end
    end

    assign stall_o = instr_valid_i & ~instr_done_o & ~abort;

    ibex_sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk  (CK),
        .rst  (RST),
        .en   (stall_o),
        .count(stall_cnt_o)
    );

endmodule

// File: tb/tb_ibex_id_seq.sv
// tb_ibex_id_seq: directed and randomized checks of ibex_id_seq against a behavioural model.
module tb_ibex_id_seq;

    localparam int LSU_TO = 8;

    logic clk = 1'b0;
    logic rst, valid, illegal, jump, branch, dreq, mul, div, taken, resp, err, mdd, flush;
    logic new_o, done_o, pc_o, lsu_o, md_o, exc_o, stall_o;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // model: kind 0 idle, 1 jump, 2 taken branch, 3 load/store, 4 mult/div
    int m_kind = 0;
    int m_age  = 0;
    int m_stall = 0;

    always #5 clk = ~clk;

    ibex_id_seq #(.LSU_TIMEOUT(LSU_TO), .RV32M(1'b1)) dut (
        .CK(clk), .RST(rst), .instr_valid_i(valid), .illegal_insn_i(illegal),
        .jump_in_dec_i(jump), .branch_in_dec_i(branch), .data_req_dec_i(dreq),
        .mult_en_dec_i(mul), .div_en_dec_i(div), .branch_taken_i(taken),
        .lsu_resp_valid_i(resp), .lsu_err_i(err), .multdiv_done_i(mdd), .flush_i(flush),
        .instr_new_o(new_o), .instr_done_o(done_o), .pc_set_o(pc_o), .lsu_req_o(lsu_o),
        .multdiv_en_o(md_o), .exc_o(exc_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic clr();
        {rst, valid, illegal, jump, branch, dreq, mul, div, taken, resp, err, mdd, flush} = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        clr();
    endtask

    always @(negedge clk) begin : cmp
        int nk;
        logic [6:0] e;
        e  = '0;
        nk = 0;
        if (!(rst || flush)) begin
            if (m_kind == 0) begin
                if (valid) begin
                    nk = illegal ? 0 : jump ? 1 : branch ? (taken ? 2 : 0) : dreq ? 3 : (mul || div) ? 4 : 0;
                    e[6] = 1'b1;
                    e[5] = nk == 0;
                    e[4] = !illegal && jump;
                    e[3] = nk == 3;
                    e[2] = nk == 4;
                    e[1] = illegal;
                end
            end else if (m_kind == 1) e[5] = 1'b1;
            else if (m_kind == 2) e[5:4] = 2'b11;
            else if (m_kind == 3) begin
                e[5] = resp || m_age == LSU_TO;
                e[1] = resp ? err : (m_age == LSU_TO);
            end else begin
                e[2] = 1'b1;
                e[5] = mdd;
            end
            e[0] = valid & ~e[5];
        end
        chk("outputs", {25'd0, new_o, done_o, pc_o, lsu_o, md_o, exc_o, stall_o}, {25'd0, e});
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
        if (rst) begin
            m_kind  <= 0;
            m_age   <= 0;
            m_stall <= 0;
        end else begin
            m_stall <= (e[0] && m_stall < 65535) ? m_stall + 1 : m_stall;
            if (flush) m_kind <= 0;
            else if (m_kind == 0) begin
                m_kind <= valid ? nk : 0;
                m_age  <= 1;
            end else if (e[5]) m_kind <= 0;
            else m_age <= m_age + 1;
        end
    end

    initial begin
        int pulses;
        clr();
        rst = 1'b1;
        next();
        rst = 1'b1;
        next();
        #1;
        chk("rst_outputs", {new_o, done_o, pc_o, lsu_o, md_o, exc_o, stall_o}, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        next(); valid = 1; jump = 1; #1;
        chk("jal_c0_new", new_o, 1);
        chk("jal_c0_pc", pc_o, 1);
        chk("jal_c0_done", done_o, 0);
        next(); valid = 1; jump = 1; #1;
        chk("jal_c1_done", done_o, 1);
        chk("jal_c1_new", new_o, 0);
        next(); #1;
        chk("jal_stall_cnt", stall_cnt, 1);

        next(); valid = 1; branch = 1; #1;
        chk("bnt_c0_done", done_o, 1);
        chk("bnt_c0_pc", pc_o, 0);
        next(); valid = 1; branch = 1; taken = 1; #1;
        chk("bt_c0_done", done_o, 0);
        next(); valid = 1; branch = 1; #1;
        chk("bt_c1_pc", pc_o, 1);
        chk("bt_c1_done", done_o, 1);

        pulses = 0;
        for (int c = 0; c <= 4; c++) begin
            next(); valid = 1; dreq = 1;
            if (c == 4) begin resp = 1; err = 1; end
            #1;
            pulses += int'(lsu_o);
            if (c == 0) chk("ld_c0_req", lsu_o, 1);
            if (c == 4) begin
                chk("ld_c4_done", done_o, 1);
                chk("ld_c4_exc", exc_o, 1);
            end
        end
        chk("ld_req_pulses", pulses, 1);

        for (int c = 0; c <= 8; c++) begin
            next(); valid = 1; dreq = 1; #1;
            if (c > 0 && c < 8) chk("to_wait_done", done_o, 0);
            if (c == 8) begin
                chk("to_c8_done", done_o, 1);
                chk("to_c8_exc", exc_o, 1);
            end
        end
        for (int c = 0; c <= 8; c++) begin
            next(); valid = 1; dreq = 1;
            if (c == 8) resp = 1;
            #1;
            if (c == 8) begin
                chk("to_resp_done", done_o, 1);
                chk("to_resp_exc", exc_o, 0);
            end
        end

        for (int c = 0; c <= 4; c++) begin
            next(); valid = 1;
            if (c < 4) div = 1;
            if (c == 3) flush = 1;
            #1;
            if (c < 3) chk("div_md_en", md_o, 1);
            if (c == 3) begin
                chk("div_flush_md", md_o, 0);
                chk("div_flush_done", done_o, 0);
            end
            if (c == 4) begin
                chk("add_new", new_o, 1);
                chk("add_done", done_o, 1);
            end
        end

        repeat (3000) begin
            next();
            rst     = $urandom_range(0, 199) == 0;
            flush   = $urandom_range(0, 29) == 0;
            valid   = $urandom_range(0, 9) < 8;
            illegal = $urandom_range(0, 19) == 0;
            jump    = $urandom_range(0, 6) == 0;
            branch  = $urandom_range(0, 4) == 0;
            taken   = $urandom_range(0, 1) == 1;
            dreq    = $urandom_range(0, 3) == 0;
            mul     = $urandom_range(0, 9) == 0;
            div     = $urandom_range(0, 9) == 0;
            resp    = $urandom_range(0, 3) == 0;
            err     = $urandom_range(0, 2) == 0;
            mdd     = $urandom_range(0, 2) == 0;
        end

        next(); flush = 1;
        repeat (70000) begin
            next(); valid = 1; div = 1;
        end
        #1;
        chk("stall_sat", stall_cnt, 16'hFFFF);
        next(); rst = 1;
        next(); #1;
        chk("stall_rst", stall_cnt, 0);
        next();
        next();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
